// File: rtl/amp_mod_pkg.sv
// rtl/amp_mod_pkg.sv - FSM states and sizing helpers for amplitude_modulator_mc
package amp_mod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENV,
        GAIN,
        OUT
    } amp_state_e;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic [31:0] gain_unity(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/amp_gain_ramp.sv
// rtl/amp_gain_ramp.sv - saturating slew register: current steps toward target on each update strobe
module amp_gain_ramp #(
    parameter int W    = 8,
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         update,
    input  logic [W-1:0] target,
    output logic [W-1:0] current
);

    localparam logic [W-1:0] STEP_V = W'(STEP);

    logic [W-1:0] cur_q, cur_d;
    logic [W-1:0] diff;

    always_comb begin
        cur_d = cur_q;
        diff  = (cur_q < target) ? (target - cur_q) : (cur_q - target);
        if (update) begin
            // The last partial step lands exactly on target, so there is never overshoot.
            if (STEP == 0 || diff <= STEP_V) begin
                cur_d = target;
            end else if (cur_q < target) begin
                cur_d = cur_q + STEP_V;
            end else begin
                cur_d = cur_q - STEP_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign current = cur_q;

endmodule

// File: rtl/amplitude_modulator_mc.sv
// rtl/amplitude_modulator_mc.sv - NUM_CH samples x envelope x slewed master gain on one shared multiplier
// AMP_MOD_SIGNED_EN selects two's-complement samples with arithmetic (floor) shifts.
module amplitude_modulator_mc
    import amp_mod_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int ENV_W     = 8,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [NUM_CH*DATA_W-1:0] waveform_in,
    input  logic [NUM_CH*ENV_W-1:0]  envelope_in,
    input  logic [GAIN_W-1:0]        master_gain,
    input  logic                     mute,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] amplitude_out,
    output logic [GAIN_W-1:0]        gain_current
);

    localparam int CH_W  = ch_idx_w(NUM_CH);
    localparam int OPB_W = (ENV_W > GAIN_W) ? ENV_W : GAIN_W;
    localparam int MUL_W = DATA_W + OPB_W;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(gain_unity(GAIN_W));
    localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(NUM_CH - 1);

    amp_state_e                state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [NUM_CH*DATA_W-1:0]  wave_q, wave_d;
    logic [NUM_CH*ENV_W-1:0]   env_q, env_d;
    logic [NUM_CH*DATA_W-1:0]  stage_q, stage_d;
    logic [NUM_CH*DATA_W-1:0]  amp_q, amp_d;
    logic [DATA_W-1:0]         e_q, e_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept;
    logic [GAIN_W-1:0]         gain_target;
    logic [DATA_W-1:0]         wave_sel, mul_a, mul_res;
    logic [ENV_W-1:0]          env_sel;
    logic [OPB_W-1:0]          mul_b;

    assign sample_ready = (state_q == IDLE);
    assign accept       = sample_valid && sample_ready;
    assign gain_target  = mute ? '0 : master_gain;

    amp_gain_ramp #(
        .W    (GAIN_W),
        .STEP (RAMP_STEP)
    ) u_gain_ramp (
        .clk     (clk),
        .rst     (rst),
        .update  (accept),
        .target  (gain_target),
        .current (gain_current)
    );

    always_comb begin
        wave_sel = '0;
        env_sel  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                wave_sel = wave_q[k*DATA_W +: DATA_W];
                env_sel  = env_q[k*ENV_W +: ENV_W];
            end
        end
    end

    // ENV multiplies sample x envelope; GAIN reuses the same multiplier for e x gain.
    always_comb begin
        mul_a = wave_sel;
        mul_b = OPB_W'(env_sel);
        if (state_q == GAIN) begin
            mul_a = e_q;
            mul_b = OPB_W'(gain_current);
        end
    end

`ifdef AMP_MOD_SIGNED_EN
    localparam int P_W = MUL_W + 1;
    logic signed [P_W-1:0] mul_p, mul_sh;
    always_comb begin
        mul_p  = P_W'($signed(mul_a)) * P_W'($signed({1'b0, mul_b}));
        mul_sh = (state_q == GAIN) ? (mul_p >>> GAIN_W) : (mul_p >>> ENV_W);
    end
`else
    logic [MUL_W-1:0] mul_p, mul_sh;
    always_comb begin
        mul_p  = MUL_W'(mul_a) * MUL_W'(mul_b);
        mul_sh = (state_q == GAIN) ? (mul_p >> GAIN_W) : (mul_p >> ENV_W);
    end
`endif

    assign mul_res = DATA_W'(mul_sh);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wave_d      = wave_q;
        env_d       = env_q;
        e_d         = e_q;
        stage_d     = stage_q;
        amp_d       = amp_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wave_d  = waveform_in;
                    env_d   = envelope_in;
                    ch_d    = '0;
                    state_d = ENV;
                end
            end
            ENV: begin
                e_d     = mul_res;
                state_d = GAIN;
            end
            GAIN: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_q == CH_W'(k)) begin
                        stage_d[k*DATA_W +: DATA_W] = (gain_current == GAIN_UNITY) ? e_q : mul_res;
                    end
                end
                if (ch_q == CH_LAST) begin
                    state_d = OUT;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = ENV;
                end
            end
            OUT: begin
                amp_d       = stage_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            wave_q      <= '0;
            env_q       <= '0;
            e_q         <= '0;
            stage_q     <= '0;
            amp_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wave_q      <= wave_d;
            env_q       <= env_d;
            e_q         <= e_d;
            stage_q     <= stage_d;
            amp_q       <= amp_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign amplitude_out = amp_q;

endmodule

// File: tb/tb_amplitude_modulator_mc.sv
// tb/tb_amplitude_modulator_mc.sv - directed-vector bench for amplitude_modulator_mc (RAMP_STEP 0 and 16)
module tb_amplitude_modulator_mc;

`ifdef AMP_MOD_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sample_valid;
    logic [31:0] waveform_in;
    logic [31:0] envelope_in;
    logic [7:0]  master_gain;
    logic        mute;

    logic        ready0, ready16, ov0, ov16;
    logic [31:0] amp0, amp16;
    logic [7:0]  gain0, gain16;

    amplitude_modulator_mc #(
        .NUM_CH(4), .DATA_W(8), .ENV_W(8), .GAIN_W(8), .RAMP_STEP(0)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_ready  (ready0),
        .waveform_in   (waveform_in),
        .envelope_in   (envelope_in),
        .master_gain   (master_gain),
        .mute          (mute),
        .out_valid     (ov0),
        .amplitude_out (amp0),
        .gain_current  (gain0)
    );

    amplitude_modulator_mc #(
        .NUM_CH(4), .DATA_W(8), .ENV_W(8), .GAIN_W(8), .RAMP_STEP(16)
    ) dut16 (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_ready  (ready16),
        .waveform_in   (waveform_in),
        .envelope_in   (envelope_in),
        .master_gain   (master_gain),
        .mute          (mute),
        .out_valid     (ov16),
        .amplitude_out (amp16),
        .gain_current  (gain16)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] e;
        logic [7:0]  g;
        logic        m;
        logic [31:0] y;
    } vec_t;

    vec_t vt [10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic frame(input logic [31:0] w, input logic [31:0] e, input logic [7:0] g,
                         input logic m, output logic [31:0] y0, output logic [31:0] y16,
                         output int lat, output int busy);
        @(negedge clk);
        waveform_in  = w;
        envelope_in  = e;
        master_gain  = g;
        mute         = m;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        waveform_in  = ~w;
        envelope_in  = ~e;
        master_gain  = ~g;
        mute         = ~m;
        lat  = 0;
        busy = 0;
        while (!ov0 && lat < 40) begin
            if (!ready0) busy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y0  = amp0;
        y16 = amp16;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] y0, y16;
        int          lat, busy, pulses;
        int          pidx[$];
        logic [31:0] pval[$];
        logic [7:0]  ramp_exp [9];
        logic [31:0] hs_exp [3];

        vt[0] = '{32'h80808080, 32'hFFFFFFFF, 8'hFF, 1'b0, SGN ? 32'h80808080 : 32'h7F7F7F7F};
        vt[1] = '{32'h80808080, 32'hFFFFFFFF, 8'h80, 1'b0, SGN ? 32'hC0C0C0C0 : 32'h3F3F3F3F};
        vt[2] = '{32'h80808080, 32'hFF00FFFF, 8'h80, 1'b0, SGN ? 32'hC000C0C0 : 32'h3F003F3F};
        vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1'b0, SGN ? 32'hFFFFFFFF : 32'hFEFEFEFE};
        vt[4] = '{32'h102040C8, 32'h80FF40FF, 8'hFF, 1'b0, SGN ? 32'h081F10C8 : 32'h081F10C7};
        vt[5] = '{32'h80808080, 32'hFFFFFFFF, 8'hFF, 1'b1, 32'h00000000};
        vt[6] = '{32'h64646464, 32'hC8C8C8C8, 8'hC0, 1'b0, 32'h3A3A3A3A};
        vt[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'h01, 1'b0, SGN ? 32'hFFFFFFFF : 32'h00000000};
        vt[8] = '{32'h80808080, 32'h80808080, 8'hFF, 1'b0, SGN ? 32'hC0C0C0C0 : 32'h40404040};
        vt[9] = '{32'h7F7F7F7F, 32'hFFFFFFFF, 8'hFF, 1'b0, 32'h7E7E7E7E};

        ramp_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
        hs_exp   = '{32'h00000000, 32'h4F4F4F4F, SGN ? 32'hA0A0A0A0 : 32'h9F9F9F9F};

        rst          = 1'b1;
        sample_valid = 1'b0;
        waveform_in  = '0;
        envelope_in  = '0;
        master_gain  = '0;
        mute         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_amp", amp0, 32'h0);
        check("reset_out_valid", {31'b0, ov0}, 32'h0);
        check("reset_ready", {31'b0, ready0}, 32'h1);
        check("reset_gain0", {24'b0, gain0}, 32'h0);
        check("reset_gain16", {24'b0, gain16}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            frame(vt[i].w, vt[i].e, vt[i].g, vt[i].m, y0, y16, lat, busy);
            check($sformatf("vec%0d_amp", i), y0, vt[i].y);
            check($sformatf("vec%0d_latency", i), lat, 32'd9);
            check($sformatf("vec%0d_busy", i), busy, 32'd9);
        end

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            frame(32'h80808080, 32'hFFFFFFFF, 8'h40, (i >= 5), y0, y16, lat, busy);
            check($sformatf("ramp%0d_gain", i), {24'b0, gain16}, {24'b0, ramp_exp[i]});
            if (i == 0) check("ramp0_amp", y16, SGN ? 32'hF8F8F8F8 : 32'h07070707);
            if (i == 8) check("ramp_mute_amp", y16, 32'h0);
        end

        @(negedge clk);
        waveform_in  = 32'h80808080;
        envelope_in  = 32'hFFFFFFFF;
        master_gain  = 8'hFF;
        mute         = 1'b0;
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {31'b0, ready0}, 32'h1);
        check("midrst_out_valid", {31'b0, ov0}, 32'h0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (ov0) pulses++;
        end
        check("midrst_no_pulse", pulses, 32'd0);
        check("midrst_amp", amp0, 32'h0);

        envelope_in = 32'hFFFFFFFF;
        master_gain = 8'hFF;
        mute        = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (ov0) begin
                pidx.push_back(i);
                pval.push_back(amp0);
            end
            sample_valid = (i < 30);
            waveform_in  = {4{8'(i * 8)}};
        end
        sample_valid = 1'b0;
        check("hs_count", pidx.size(), 32'd3);
        if (pidx.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("hs%0d_index", k), pidx[k], 32'(10 * (k + 1)));
                check($sformatf("hs%0d_amp", k), pval[k], hs_exp[k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
